// File: rtl/img_stream_loader_pkg.sv
// ---------------------------------------------------------------------------
// img_stream_loader_pkg
//   Shared types for the image SRAM loader: SRAM write-port bundle, loader
//   FSM state type and the minimum legal image width.
// ---------------------------------------------------------------------------
package img_stream_loader_pkg;

    localparam int SRAM_ROW_W  = 8;
    localparam int SRAM_COL_W  = 8;
    localparam int SRAM_DATA_W = 8;

    // Narrowest image the row-convolution pass can handle.
    localparam int MIN_NCOLS = 6;

    typedef struct packed {
        logic                   write_en;
        logic                   sense_en;
        logic [SRAM_ROW_W-1:0]  row;
        logic [SRAM_COL_W-1:0]  col;
        logic [SRAM_DATA_W-1:0] din;
    } img_sram_ctrl_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

endpackage

// File: rtl/img_stream_loader_if.sv
// ---------------------------------------------------------------------------
// img_stream_loader_if
//   Valid/ready pixel stream.
//   s_valid : beat valid (source -> sink)
//   s_ready : sink can accept (sink -> source)
//   s_data  : pixel value
//   s_last  : final pixel of the image
// ---------------------------------------------------------------------------
interface img_stream_loader_if #(
    parameter int DATA_W = 8
) ();
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_last;

    modport master (output s_valid, output s_data, output s_last, input s_ready);
    modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/img_stream_loader_raster_counter.sv
// ---------------------------------------------------------------------------
// img_raster_counter
//   Raster-order row/column counter.
//   clk, rst     : clock, async active-high reset
//   en           : advance one position
//   clr          : return to (0,0); wins over en
//   nrows, ncols : image dimensions (held stable while counting)
//   row, col     : current position
//   last         : current position is the final pixel of the image
// ---------------------------------------------------------------------------
module img_raster_counter #(
    parameter int ROW_W = 8,
    parameter int COL_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [ROW_W-1:0] nrows,
    input  logic [COL_W-1:0] ncols,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last
);
    logic col_last;

    assign col_last = (col == ncols - COL_W'(1));
    assign last     = col_last && (row == nrows - ROW_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (en) begin
            if (col_last) begin
                col <= '0;
                row <= row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end
endmodule

// File: rtl/img_stream_loader.sv
// ---------------------------------------------------------------------------
// img_stream_loader
//   Writes a raster-order pixel stream into the image SRAM and raises
//   conv_go once the whole image is stored.
//   clk, rst       : clock, async active-high reset
//   start          : 1-cycle request, samples nrows/ncols
//   nrows, ncols   : image size (1..255 rows, 6..255 cols)
//   s              : pixel stream (sink side)
//   sram_img_ctrl  : registered SRAM write port
//   busy           : loader not idle
//   done           : 1-cycle pulse, image fully written
//   err            : sticky error, cleared by next accepted start
//   conv_go        : held high from completion until next accepted start
// ---------------------------------------------------------------------------
module img_stream_loader
    import img_stream_loader_pkg::*;
#(
    parameter int ROW_W  = SRAM_ROW_W,
    parameter int COL_W  = SRAM_COL_W,
    parameter int DATA_W = SRAM_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ROW_W-1:0]      nrows,
    input  logic [COL_W-1:0]      ncols,
    img_stream_loader_if.slave    s,
    output img_sram_ctrl_t        sram_img_ctrl,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  conv_go
);
    loader_state_t    state;
    logic [ROW_W-1:0] nrows_q;
    logic [COL_W-1:0] ncols_q;
    logic [ROW_W-1:0] cnt_row;
    logic [COL_W-1:0] cnt_col;
    logic             cnt_last;
    logic             dims_ok;
    logic             accept;
    logic             cnt_clr;

    assign dims_ok = (ncols >= COL_W'(MIN_NCOLS)) && (nrows != '0);
    // s_ready is only ever high in LOAD, but qualify anyway so the counter
    // cannot move on a stale ready.
    assign accept  = (state == LOAD) && s.s_valid && s.s_ready;
    assign cnt_clr = (state == IDLE) && start && dims_ok;

    img_raster_counter #(
        .ROW_W (ROW_W),
        .COL_W (COL_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (accept),
        .clr   (cnt_clr),
        .nrows (nrows_q),
        .ncols (ncols_q),
        .row   (cnt_row),
        .col   (cnt_col),
        .last  (cnt_last)
    );

    // done/conv_go are set on the edge that accepts the final beat, so the
    // done pulse lines up with that beat's write and with the DONE state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            s.s_ready     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            conv_go       <= 1'b0;
            sram_img_ctrl <= '0;
            nrows_q       <= '0;
            ncols_q       <= '0;
        end else begin
            done                   <= 1'b0;
            sram_img_ctrl.write_en <= 1'b0;
            sram_img_ctrl.sense_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (!dims_ok) begin
                            err <= 1'b1;
                        end else begin
                            nrows_q   <= nrows;
                            ncols_q   <= ncols;
                            err       <= 1'b0;
                            conv_go   <= 1'b0;
                            s.s_ready <= 1'b1;
                            busy      <= 1'b1;
                            state     <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        sram_img_ctrl.write_en <= 1'b1;
                        sram_img_ctrl.row      <= cnt_row;
                        sram_img_ctrl.col      <= cnt_col;
                        sram_img_ctrl.din      <= s.s_data;
                        if (cnt_last) begin
                            state     <= DONE;
                            s.s_ready <= 1'b0;
                            done      <= 1'b1;
                            conv_go   <= 1'b1;
                            if (!s.s_last) err <= 1'b1;
                        end else if (s.s_last) begin
                            err       <= 1'b1;
                            state     <= IDLE;
                            s.s_ready <= 1'b0;
                            busy      <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    s.s_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_img_stream_loader.sv
module tb_img_stream_loader;
    import img_stream_loader_pkg::*;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [7:0]     nrows = '0;
    logic [7:0]     ncols = '0;
    img_sram_ctrl_t sram;
    logic           busy, done, err, conv_go;

    img_stream_loader_if #(.DATA_W(8)) sif ();

    img_stream_loader #(.ROW_W(8), .COL_W(8), .DATA_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .nrows         (nrows),
        .ncols         (ncols),
        .s             (sif.slave),
        .sram_img_ctrl (sram),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .conv_go       (conv_go)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: every cycle with write_en high is one SRAM write.
    typedef struct { int row; int col; int din; int stamp; } wr_t;
    wr_t wr_q[$];
    int  done_cnt = 0;
    int  done_stamp = -1;

    always @(negedge clk) begin
        if (sram.write_en)
            wr_q.push_back('{int'(sram.row), int'(sram.col), int'(sram.din), cyc});
        if (done) begin
            done_cnt++;
            done_stamp = cyc;
        end
    end

    int compared = 0;
    int mismatched = 0;

    function automatic void check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Reference outcome of one image transfer, from the stream rules alone.
    function automatic void ref_model(input int nr, input int nc, input int last_at,
                                      output int w, output int dn, output int er, output int go);
        int total;
        total = nr * nc;
        if (last_at >= 1 && last_at < total) begin
            w = last_at; dn = 0; er = 1; go = 0;
        end else begin
            w = total; dn = 1; er = (last_at == total) ? 0 : 1; go = 1;
        end
    endfunction

    // vmode: 0 = always valid, 1 = toggling valid, 2 = random valid
    // last_at: 1-based beat index carrying s_last, 0 = never
    task automatic run_img(input string name, input int nr, input int nc, input int last_at,
                           input int vmode, input int dmode,
                           input int ex_w, input int ex_done, input int ex_err, input int ex_go);
        int  sent, guard, d, st;
        int  acc_st[$];
        int  dat[$];
        bit  stop, v, rdy;
        wr_q.delete();
        done_cnt = 0;
        done_stamp = -1;
        @(negedge clk);
        start = 1'b1; nrows = 8'(nr); ncols = 8'(nc);
        @(negedge clk);
        start = 1'b0;
        check({name, ".busy_after_start"}, int'(busy), 1);
        check({name, ".err_after_start"}, int'(err), 0);
        check({name, ".go_after_start"}, int'(conv_go), 0);
        sent = 0; guard = 0; stop = 0;
        while (!stop && guard < 400) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = (guard % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            d = dmode ? int'($urandom_range(0, 255)) : (sent % 256);
            sif.s_valid = v;
            sif.s_data  = 8'(d);
            sif.s_last  = (sent + 1 == last_at);
            rdy = sif.s_ready;
            st  = cyc;
            @(posedge clk);
            if (v && rdy) begin
                acc_st.push_back(st);
                dat.push_back(d);
                sent++;
                if (sif.s_last || sent == nr * nc) stop = 1'b1;
            end
            @(negedge clk);
            guard++;
        end
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
        check({name, ".finished_in_budget"}, int'(stop), 1);
        repeat (4) @(negedge clk);
        check({name, ".beats_accepted"}, sent, ex_w);
        check({name, ".writes"}, wr_q.size(), ex_w);
        for (int i = 0; i < wr_q.size() && i < sent; i++) begin
            check($sformatf("%s.row[%0d]", name, i), wr_q[i].row, i / nc);
            check($sformatf("%s.col[%0d]", name, i), wr_q[i].col, i % nc);
            check($sformatf("%s.din[%0d]", name, i), wr_q[i].din, dat[i]);
            check($sformatf("%s.latency[%0d]", name, i), wr_q[i].stamp, acc_st[i] + 1);
        end
        check({name, ".done_pulses"}, done_cnt, ex_done);
        if (ex_done != 0 && wr_q.size() > 0)
            check({name, ".done_with_last_write"}, done_stamp, wr_q[wr_q.size()-1].stamp);
        check({name, ".err"}, int'(err), ex_err);
        check({name, ".conv_go"}, int'(conv_go), ex_go);
        check({name, ".busy_end"}, int'(busy), 0);
        check({name, ".ready_end"}, int'(sif.s_ready), 0);
    endtask

    typedef struct {
        string name;
        int nr; int nc; int last_at; int vmode;
        int ex_w; int ex_done; int ex_err; int ex_go;
    } vec_t;
    vec_t tbl[4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, dn, er, go, nr, nc, la, sel;

        tbl[0] = '{"b2b_2x6",     2, 6, 12, 0, 12, 1, 0, 1};
        tbl[1] = '{"toggle_2x6",  2, 6, 12, 1, 12, 1, 0, 1};
        tbl[2] = '{"early_last",  3, 8, 10, 0, 10, 0, 1, 0};
        tbl[3] = '{"no_last_1x6", 1, 6,  0, 0,  6, 1, 1, 1};

        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        sif.s_last  = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst.write_en", int'(sram.write_en), 0);
        check("rst.sense_en", int'(sram.sense_en), 0);
        check("rst.sram_all", int'(sram != '0), 0);
        check("rst.s_ready", int'(sif.s_ready), 0);
        check("rst.busy", int'(busy), 0);
        check("rst.done", int'(done), 0);
        check("rst.err", int'(err), 0);
        check("rst.conv_go", int'(conv_go), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++)
            run_img(tbl[i].name, tbl[i].nr, tbl[i].nc, tbl[i].last_at, tbl[i].vmode, 0,
                    tbl[i].ex_w, tbl[i].ex_done, tbl[i].ex_err, tbl[i].ex_go);

        // Illegal dimensions: narrow image, then zero rows
        wr_q.delete();
        @(negedge clk);
        start = 1'b1; nrows = 8'd2; ncols = 8'd5; sif.s_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("narrow.err", int'(err), 1);
        check("narrow.busy", int'(busy), 0);
        check("narrow.ready", int'(sif.s_ready), 0);
        check("narrow.conv_go_held", int'(conv_go), 1);
        start = 1'b1; nrows = 8'd0; ncols = 8'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("zero_rows.err", int'(err), 1);
        check("zero_rows.busy", int'(busy), 0);
        check("zero_rows.ready", int'(sif.s_ready), 0);
        check("zero_rows.writes", wr_q.size(), 0);
        check("zero_rows.conv_go_held", int'(conv_go), 1);
        sif.s_valid = 1'b0;

        // Reset in the middle of a load
        @(negedge clk);
        start = 1'b1; nrows = 8'd2; ncols = 8'd6;
        @(negedge clk);
        start = 1'b0;
        sif.s_valid = 1'b1; sif.s_data = 8'hA5; sif.s_last = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst.write_before", int'(sram.write_en), 1);
        #2 rst = 1'b1;
        #1;
        check("midrst.write_en", int'(sram.write_en), 0);
        check("midrst.ready", int'(sif.s_ready), 0);
        check("midrst.busy", int'(busy), 0);
        check("midrst.done", int'(done), 0);
        check("midrst.err", int'(err), 0);
        check("midrst.conv_go", int'(conv_go), 0);
        check("midrst.row", int'(sram.row), 0);
        sif.s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start = 1'b1; nrows = 8'd1; ncols = 8'd3;
        @(negedge clk);
        start = 1'b0;
        check("postrst.illegal_err", int'(err), 1);
        run_img("postrst_2x6", 2, 6, 12, 0, 1, 12, 1, 0, 1);

        // Randomized transfers against the reference model
        for (int t = 0; t < 6; t++) begin
            nr  = int'($urandom_range(1, 4));
            nc  = int'($urandom_range(6, 10));
            sel = int'($urandom_range(0, 2));
            la  = (sel == 0) ? 0 : (sel == 1) ? nr * nc : int'($urandom_range(1, nr * nc - 1));
            ref_model(nr, nc, la, w, dn, er, go);
            run_img($sformatf("rand%0d", t), nr, nc, la, 2, 1, w, dn, er, go);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
